// File: rtl/sram_port_arbiter_if.sv
// sram_port_arbiter_if: one requester port of the SRAM arbiter (request, write bus, grant, read return, grant count).
interface sram_port_arbiter_if #(
  parameter int SRAM_ADDR_WIDTH = 16,
  parameter int SRAM_DATA_WIDTH = 32,
  parameter int CNT_WIDTH       = 16
);
  logic                         req;
  logic                         lock;
  logic [SRAM_ADDR_WIDTH-1:0]   addr;
  logic [SRAM_DATA_WIDTH/8-1:0] wstrb;
  logic [SRAM_DATA_WIDTH-1:0]   wdata;
  logic                         gnt;
  logic                         rvalid;
  logic [SRAM_DATA_WIDTH-1:0]   rdata;
  logic [CNT_WIDTH-1:0]         gnt_cnt;
  modport master (output req, lock, addr, wstrb, wdata, input gnt, rvalid, rdata, gnt_cnt);
  modport slave  (input req, lock, addr, wstrb, wdata, output gnt, rvalid, rdata, gnt_cnt);
endinterface

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: two-port round-robin arbiter onto a single-port SRAM with lock (RMW) support.
module sram_port_arbiter #(
  parameter int SRAM_ADDR_WIDTH = 16,
  parameter int SRAM_DATA_WIDTH = 32,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                         sram_clk,
  input  logic                         sram_rst_n,
  sram_port_arbiter_if.slave           m0_if,
  sram_port_arbiter_if.slave           m1_if,
  output logic [SRAM_ADDR_WIDTH-1:0]   sram_addr_o,
  output logic [SRAM_DATA_WIDTH-1:0]   sram_din_o,
  output logic [SRAM_DATA_WIDTH/8-1:0] sram_we_o,
  output logic                         sram_en_o,
  input  logic [SRAM_DATA_WIDTH-1:0]   sram_dout_i
);
  typedef enum logic [1:0] {ARB, LOCK0, LOCK1} state_e;
  state_e               state_q, state_d;
  logic                 last_q, last_d;
  logic [1:0]           rd_q, rd_d;
  logic [CNT_WIDTH-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
  logic                 gnt0, gnt1;
  // last_q=1 means port 1 won most recently, so port 0 has priority on contention
  always_comb begin
    gnt0 = sram_rst_n && m0_if.req && (state_q == LOCK0 || (state_q == ARB && (!m1_if.req || last_q)));
    gnt1 = sram_rst_n && m1_if.req && (state_q == LOCK1 || (state_q == ARB && (!m0_if.req || !last_q)));
    state_d = state_q;
    if (state_q == ARB)
      state_d = (gnt0 && m0_if.lock) ? LOCK0 : (gnt1 && m1_if.lock) ? LOCK1 : ARB;
    else if (state_q == LOCK0 && !m0_if.lock)
      state_d = ARB;
    else if (state_q == LOCK1 && !m1_if.lock)
      state_d = ARB;
    last_d = gnt0 ? 1'b0 : gnt1 ? 1'b1 : last_q;
    rd_d = {gnt1 && ~|m1_if.wstrb, gnt0 && ~|m0_if.wstrb};
    cnt0_d = cnt0_q + CNT_WIDTH'(gnt0 && !(&cnt0_q));
    cnt1_d = cnt1_q + CNT_WIDTH'(gnt1 && !(&cnt1_q));
    sram_en_o = gnt0 || gnt1;
    sram_addr_o = gnt0 ? m0_if.addr : gnt1 ? m1_if.addr : '0;
    sram_din_o = gnt0 ? m0_if.wdata : gnt1 ? m1_if.wdata : '0;
    sram_we_o = gnt0 ? m0_if.wstrb : gnt1 ? m1_if.wstrb : '0;
  end
  always_ff @(posedge sram_clk or negedge sram_rst_n) begin
    if (!sram_rst_n) begin
      state_q <= ARB;
      last_q  <= 1'b1;
      rd_q    <= '0;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      rd_q    <= rd_d;
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
    end
  end
  assign m0_if.gnt     = gnt0;
  assign m1_if.gnt     = gnt1;
  assign m0_if.rvalid  = rd_q[0];
  assign m1_if.rvalid  = rd_q[1];
  assign m0_if.rdata   = sram_dout_i;
  assign m1_if.rdata   = sram_dout_i;
  assign m0_if.gnt_cnt = cnt0_q;
  assign m1_if.gnt_cnt = cnt1_q;
endmodule

// File: doc/sram_port_arbiter.md
SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

Interface
REQ-001 SHALL have parameter SRAM_ADDR_WIDTH, default 16, SRAM word address width.
REQ-002 SHALL have parameter SRAM_DATA_WIDTH, default 32, SRAM data width; multiple of 8; STRB_W = SRAM_DATA_WIDTH/8.
REQ-003 SHALL have parameter CNT_WIDTH, default 16, grant-counter width.
REQ-004 sram_clk  input  1  clock; all logic rising-edge.
REQ-005 sram_rst_n  input  1  reset, asynchronous, active-low.
REQ-006 mN_req  input  1  port N (N=0,1) request valid.
REQ-007 mN_lock  input  1  port N holds the SRAM after the current grant (read-modify-write).
REQ-008 mN_addr  input  SRAM_ADDR_WIDTH  port N word address.
REQ-009 mN_wstrb  input  STRB_W  port N byte enables; all-zero means read.
REQ-010 mN_wdata  input  SRAM_DATA_WIDTH  port N write data.
REQ-011 mN_gnt  output  1  port N request accepted this cycle.
REQ-012 mN_rvalid  output  1  port N read data valid; single-cycle pulse, no backpressure.
REQ-013 mN_rdata  output  SRAM_DATA_WIDTH  port N read data.
REQ-014 mN_gnt_cnt  output  CNT_WIDTH  saturating count of port N grants.
REQ-015 sram_addr, sram_din, sram_we, sram_en  output  SRAM_ADDR_WIDTH/SRAM_DATA_WIDTH/STRB_W/1  SRAM port.
REQ-016 sram_dout  input  SRAM_DATA_WIDTH  SRAM read data, valid one cycle after the sram_en cycle.

Function
REQ-017 SHALL implement FSM states ARB, LOCK0, LOCK1; reset state ARB.
REQ-018 In ARB, sole requester SHALL be granted; with both requesting, the port not granted most recently wins (round-robin); last_grant resets to 1, so port 0 wins the first contention.
REQ-019 Grant SHALL be combinational in the request cycle: mN_gnt=1 for the winner, 0 for the loser; at most one gnt high per cycle.
REQ-020 On grant SHALL drive sram_en=1, sram_addr=mN_addr, sram_din=mN_wdata, sram_we=mN_wstrb in the same cycle.
REQ-021 With no grant SHALL drive sram_en=0, sram_we=0, sram_addr=0, sram_din=0.
REQ-022 Throughput SHALL be one access per cycle; back-to-back grants to either port allowed.
REQ-023 A granted read (wstrb=0) SHALL produce mN_rvalid=1 on the granted port exactly one cycle later with mN_rdata=sram_dout; writes SHALL produce no rvalid.
REQ-024 mN_rdata SHALL pass sram_dout through; it is defined only while mN_rvalid=1.
REQ-025 Grant to port N with mN_lock=1 SHALL move ARB->LOCKN; last_grant updates to N.
REQ-026 In LOCKN only port N SHALL be granted (when mN_req=1); the other port receives no grant regardless of its request.
REQ-027 LOCKN SHALL return to ARB at the first cycle where mN_lock=0 (with or without a grant that cycle); that cycle is still owned by port N.
REQ-028 Granting with lock=0 SHALL leave the FSM in ARB.
REQ-029 mN_gnt_cnt SHALL increment by 1 per grant to port N and saturate at all-ones.
REQ-030 Requests not granted SHALL be held by the requester; the arbiter stores no request state.

Reset
REQ-031 On sram_rst_n=0, asynchronously: FSM=ARB, last_grant=1, pending-read tag cleared, mN_rvalid=0, mN_gnt_cnt=0.
REQ-032 While in reset, all mN_gnt=0 and sram_en=0, sram_we=0.
REQ-033 A read granted in the cycle before reset assertion SHALL NOT produce rvalid after reset release.

Verification
REQ-034 Both ports request reads (addr0=0x0010, addr1=0x0020) from reset for 4 cycles -> grants 0,1,0,1; rvalid on the matching port one cycle after each grant with SRAM contents.
REQ-035 m0 write wstrb=0xF data=0xDEADBEEF addr=0x0004, then m1 read addr=0x0004 -> m1_rvalid one cycle after its grant with m1_rdata=0xDEADBEEF; no m0_rvalid.
REQ-036 m0 read with lock=1, m1 requesting continuously, m0 lock held 3 cycles -> m1_gnt=0 for those cycles; m1 granted the cycle after lock drops.
REQ-037 m1 alone, 70000 consecutive grants with CNT_WIDTH=16 -> m1_gnt_cnt=0xFFFF, m0_gnt_cnt=0.
REQ-038 Assert reset the cycle after an m0 read grant -> m0_rvalid stays 0; after release, contention grants port 0 first.
